// File: rtl/write_addr_pkg.sv
// Shared types and default widths for the matrix read/write address sequencers.
package write_addr_pkg;

  localparam int ROW_W_DEF  = 2;
  localparam int COL_W_DEF  = 2;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_e;

endpackage

// File: rtl/write_address_gen_if.sv
// Handshake and write-strobe bundle for write_address_gen.
// WRITE_ADDR_TRANSPOSE_EN adds the transpose request line.
interface write_address_gen_if
  import write_addr_pkg::*;
#(
  parameter int ROW_W  = ROW_W_DEF,
  parameter int COL_W  = COL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              start;
  logic              abort;
`ifdef WRITE_ADDR_TRANSPOSE_EN
  logic              transpose;
`endif
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ROW_W-1:0]  wr_i;
  logic [COL_W-1:0]  wr_j;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, in_valid, in_data,
`ifdef WRITE_ADDR_TRANSPOSE_EN
    output transpose,
`endif
    input  in_ready, wr_en, wr_i, wr_j, wr_data, busy, done
  );

  modport slave (
    input  start, abort, in_valid, in_data,
`ifdef WRITE_ADDR_TRANSPOSE_EN
    input  transpose,
`endif
    output in_ready, wr_en, wr_i, wr_j, wr_data, busy, done
  );
endinterface

// File: rtl/addr_counter.sv
// Frame beat counter with row/col split; WRITE_ADDR_TRANSPOSE_EN adds a
// column-major swap (square buffers only).
module addr_counter
  import write_addr_pkg::*;
#(
  parameter int ROW_W = ROW_W_DEF,
  parameter int COL_W = COL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
`ifdef WRITE_ADDR_TRANSPOSE_EN
  input  logic             swap,
`endif
  output logic [ROW_W-1:0] cnt_i,
  output logic [COL_W-1:0] cnt_j,
  output logic             last
);
  localparam int CW = ROW_W + COL_W;

  logic [CW-1:0] cnt;

  // Natural wrap after the all-ones beat leaves the counter at 0 for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + CW'(1);
  end

  assign last = &cnt;

`ifdef WRITE_ADDR_TRANSPOSE_EN
  generate
    if (ROW_W == COL_W) begin : g_swap
      assign cnt_i = swap ? cnt[ROW_W-1:0]  : cnt[CW-1:COL_W];
      assign cnt_j = swap ? cnt[CW-1:ROW_W] : cnt[COL_W-1:0];
    end else begin : g_noswap
      logic unused_swap;
      assign unused_swap = swap;
      assign cnt_i = cnt[CW-1:COL_W];
      assign cnt_j = cnt[COL_W-1:0];
    end
  endgenerate
`else
  assign cnt_i = cnt[CW-1:COL_W];
  assign cnt_j = cnt[COL_W-1:0];
`endif

endmodule

// File: rtl/write_address_gen.sv
// Write-side address sequencer: accepted beats become registered (i,j,data) writes
// one cycle later. Optional macro: WRITE_ADDR_TRANSPOSE_EN (column-major order).
module write_address_gen
  import write_addr_pkg::*;
#(
  parameter int ROW_W  = ROW_W_DEF,
  parameter int COL_W  = COL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  write_address_gen_if.slave bus
);
  state_e            state;
  logic              acc, clr, last;
  logic [ROW_W-1:0]  cnt_i;
  logic [COL_W-1:0]  cnt_j;
  logic              wr_en_q, done_q;
  logic [ROW_W-1:0]  wr_i_q;
  logic [COL_W-1:0]  wr_j_q;
  logic [DATA_W-1:0] wr_data_q;

  // Abort wins over start in IDLE and blocks acceptance in RUN.
  assign bus.in_ready = (state == RUN) && !bus.abort;
  assign acc          = bus.in_valid && bus.in_ready;
  assign clr          = ((state == IDLE) && bus.start && !bus.abort) ||
                        ((state == RUN) && bus.abort);

`ifdef WRITE_ADDR_TRANSPOSE_EN
  logic tr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         tr_q <= 1'b0;
    else if ((state == IDLE) && bus.start && !bus.abort) tr_q <= bus.transpose;
  end
`endif

  addr_counter #(.ROW_W(ROW_W), .COL_W(COL_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (acc),
`ifdef WRITE_ADDR_TRANSPOSE_EN
    .swap  (tr_q),
`endif
    .cnt_i (cnt_i),
    .cnt_j (cnt_j),
    .last  (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      wr_i_q    <= '0;
      wr_j_q    <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= acc;
      done_q  <= acc && last;
      if (acc) begin
        wr_i_q    <= cnt_i;
        wr_j_q    <= cnt_j;
        wr_data_q <= bus.in_data;
      end
      unique case (state)
        IDLE:    if (bus.start && !bus.abort) state <= RUN;
        RUN:     if (bus.abort)               state <= IDLE;
                 else if (acc && last)        state <= LAST;
        LAST:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_i    = wr_i_q;
  assign bus.wr_j    = wr_j_q;
  assign bus.wr_data = wr_data_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_write_address_gen.sv
// Directed bench for write_address_gen: idle, full frame, bubbles, abort,
// start-while-busy, reset mid-frame and (if enabled) transpose order.
module tb_write_address_gen;
  import write_addr_pkg::*;

  localparam int ROW_W  = 2;
  localparam int COL_W  = 2;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  write_address_gen_if #(.ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W)) bus ();

  write_address_gen #(.ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input int i, input int j, input int d, input int dn);
    chk({tag, ".wr_en"},   32'(bus.wr_en),   32'(1));
    chk({tag, ".wr_i"},    32'(bus.wr_i),    32'(i));
    chk({tag, ".wr_j"},    32'(bus.wr_j),    32'(j));
    chk({tag, ".wr_data"}, 32'(bus.wr_data), 32'(d));
    chk({tag, ".done"},    32'(bus.done),    32'(dn));
  endtask

  task automatic chk_nowr(input string tag);
    chk({tag, ".wr_en"}, 32'(bus.wr_en), 32'(0));
    chk({tag, ".done"},  32'(bus.done),  32'(0));
  endtask

  task automatic go(input bit tr);
    bus.start = 1'b1;
`ifdef WRITE_ADDR_TRANSPOSE_EN
    bus.transpose = tr;
`else
    if (tr) $display("transpose request ignored in this build");
`endif
    tick;
    bus.start = 1'b0;
    chk("go.busy", 32'(bus.busy), 32'(1));
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
`ifdef WRITE_ADDR_TRANSPOSE_EN
    bus.transpose = 1'b0;
`endif
    // Reset values
    tick;
    chk("rst.wr_en",    32'(bus.wr_en),    32'(0));
    chk("rst.wr_i",     32'(bus.wr_i),     32'(0));
    chk("rst.wr_j",     32'(bus.wr_j),     32'(0));
    chk("rst.wr_data",  32'(bus.wr_data),  32'(0));
    chk("rst.done",     32'(bus.done),     32'(0));
    chk("rst.busy",     32'(bus.busy),     32'(0));
    chk("rst.in_ready", 32'(bus.in_ready), 32'(0));
    rst = 1'b0;

    // Idle with in_valid held and no start
    bus.in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick;
      chk("idle.in_ready", 32'(bus.in_ready), 32'(0));
      chk("idle.wr_en",    32'(bus.wr_en),    32'(0));
      chk("idle.busy",     32'(bus.busy),     32'(0));
    end

    // Simultaneous start and abort in IDLE: stay idle
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("sa.busy", 32'(bus.busy), 32'(0));

    // Full continuous frame
    go(1'b0);
    for (int k = 0; k < 16; k++) begin
      bus.in_data = 8'(k);
      #1 chk("full.in_ready", 32'(bus.in_ready), 32'(1));
      tick;
      chk_wr("full", k / 4, k % 4, k, (k == 15) ? 1 : 0);
      chk("full.busy", 32'(bus.busy), 32'(1));
    end
    // LAST cycle: no accept; a start here must be ignored
    bus.start = 1'b1;
    #1 chk("last.in_ready", 32'(bus.in_ready), 32'(0));
    tick;
    bus.start = 1'b0;
    chk("post.busy", 32'(bus.busy), 32'(0));
    chk_nowr("post");
    chk("post.hold_i", 32'(bus.wr_i),    32'(3));
    chk("post.hold_d", 32'(bus.wr_data), 32'(15));

    // Bubbles: valid on even cycles only
    go(1'b0);
    begin
      int k;
      k = 0;
      for (int c = 0; c < 32; c++) begin
        bus.in_valid = (c % 2 == 0);
        bus.in_data  = 8'(8'hA0 + k);
        tick;
        if (c % 2 == 0) begin
          chk_wr("bub", k / 4, k % 4, 8'hA0 + k, (k == 15) ? 1 : 0);
          k++;
        end else begin
          chk_nowr("bub.gap");
        end
      end
    end
    chk("bub.busy", 32'(bus.busy), 32'(0));

    // Abort after 5 accepts
    go(1'b0);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.in_data = 8'(8'h30 + k);
      tick;
      chk_wr("abt", k / 4, k % 4, 8'h30 + k, 0);
    end
    bus.abort   = 1'b1;
    bus.in_data = 8'h55;
    #1 chk("abt.in_ready", 32'(bus.in_ready), 32'(0));
    tick;
    bus.abort = 1'b0;
    chk("abt.busy", 32'(bus.busy), 32'(0));
    chk_nowr("abt.after");
    for (int c = 0; c < 3; c++) begin
      tick;
      chk_nowr("abt.idle");
    end
    go(1'b0);
    bus.in_data = 8'h77;
    tick;
    chk_wr("abt.restart", 0, 0, 8'h77, 0);
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;

    // Start pulses during RUN, then reset after 7 accepts
    go(1'b0);
    for (int k = 0; k < 7; k++) begin
      bus.start   = (k == 2 || k == 4);
      bus.in_data = 8'(8'h40 + k);
      tick;
      chk_wr("sbusy", k / 4, k % 4, 8'h40 + k, 0);
    end
    bus.start = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst.wr_en",    32'(bus.wr_en),    32'(0));
    chk("mrst.wr_i",     32'(bus.wr_i),     32'(0));
    chk("mrst.wr_j",     32'(bus.wr_j),     32'(0));
    chk("mrst.wr_data",  32'(bus.wr_data),  32'(0));
    chk("mrst.busy",     32'(bus.busy),     32'(0));
    chk("mrst.in_ready", 32'(bus.in_ready), 32'(0));
    chk("mrst.done",     32'(bus.done),     32'(0));
    tick;
    rst = 1'b0;
    go(1'b0);
    bus.in_data = 8'h99;
    tick;
    chk_wr("mrst.restart", 0, 0, 8'h99, 0);
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;

`ifdef WRITE_ADDR_TRANSPOSE_EN
    // Column-major frame: word at (i,j) is 4*j+i
    go(1'b1);
    bus.transpose = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus.in_data = 8'(k);
      tick;
      chk_wr("tr", k % 4, k / 4, k, (k == 15) ? 1 : 0);
    end
    tick;
    chk("tr.busy", 32'(bus.busy), 32'(0));
`endif

    bus.in_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/write_address_gen.md
Name: write_address_gen

Overview:
- Write-side counterpart of the matrix read-address sequencer.
- Accepts a stream of result words over a valid/ready handshake and produces registered write strobes with (i, j) coordinates and data for a ROWS x COLS result buffer, where ROWS = 2^ROW_W and COLS = 2^COL_W.
- Sits between the processing datapath and the result memory.
- Signals frame completion with a one-cycle done pulse.

Parameters:
- ROW_W, 2, width of row index i (ROWS = 2^ROW_W).
- COL_W, 2, width of column index j (COLS = 2^COL_W).
- DATA_W, 8, width of result word.

Ports:
- clk, input, 1, clock, rising-edge.
- rst, input, 1, reset, asynchronous, active-high.
- start, input, 1, begin a frame; sampled only in IDLE.
- abort, input, 1, synchronous frame cancel; return to IDLE.
- in_valid, input, 1, upstream word valid.
- in_data, input, DATA_W, upstream word.
- in_ready, output, 1, block can accept a word.
- wr_en, output, 1, memory write strobe.
- wr_i, output, ROW_W, write row index.
- wr_j, output, COL_W, write column index.
- wr_data, output, DATA_W, write data.
- busy, output, 1, frame in progress (state != IDLE).
- done, output, 1, one-cycle pulse: last word written.

Behaviour:
- Reset (async): state=IDLE, counter=0, wr_en=0, wr_i=0, wr_j=0, wr_data=0, done=0, in_ready=0, busy=0.
- States and transitions:
  - IDLE: start=1 -> RUN, counter cleared to 0.
  - RUN: handshake on the last beat -> LAST.
  - LAST: always -> IDLE.
- in_ready = (state==RUN) && !abort. It is combinational from state and abort, never from in_valid.
- Beat accepted in cycle N when in_valid && in_ready. Then, in cycle N+1: wr_en=1, {wr_i, wr_j} = counter value at N, wr_data = in_data at N. This is a fixed 1-cycle latency.
- The counter is ROW_W+COL_W bits and increments once per accepted beat. Default order is row-major: {i, j} = counter, j fastest.
- No accept in a cycle -> wr_en=0 next cycle. wr_i, wr_j and wr_data hold their last values.
- Last beat (counter all ones) accepted in cycle N:
  - state=LAST in N+1.
  - Cycle N+1 carries wr_en=1 for the final address and done=1. in_ready=0.
  - Cycle N+2: IDLE, done=0.
- Counter wraps to 0 after the last beat. A frame is exactly ROWS*COLS beats.
- start while busy: ignored. start asserted in the LAST cycle: ignored; must be reasserted in IDLE.
- abort in RUN:
  - No beat accepted that cycle.
  - Next cycle: IDLE, counter=0, done=0, wr_en=0.
  - A beat accepted in the previous cycle still completes its write in the abort cycle.
- abort in IDLE or LAST: no effect. LAST completes normally with done=1.
- Simultaneous start and abort in IDLE: abort wins, stay IDLE.
- rst mid-frame: immediate return to reset values. No partial done.
- in_valid held while in_ready=0: no accept, no write. in_data may change freely.

Optional Feature:
- Macro: WRITE_ADDR_TRANSPOSE_EN.
- When defined, adds input port transpose (1 bit), latched at start into a config register.
- When the latched value is 1, the address is column-major: wr_j = counter[ROW_W+COL_W-1:ROW_W], wr_i = counter[ROW_W-1:0]. This is valid only when ROW_W == COL_W; otherwise the port is present but ignored.
- Frame length and done timing are unchanged.
- When not defined: no port, row-major only, no extra registers.

Decomposition:
- Shared package write_addr_pkg holds:
  - State encoding typedef (IDLE, RUN, LAST).
  - Default ROW_W, COL_W and DATA_W constants, shared with the read-address sequencer.
- One natural sub-module: addr_counter. It holds the ROW_W+COL_W counter with clear, increment and all-ones (last) flag, plus the row/col split (and transpose swap when enabled).
- The top module holds the FSM, the handshake and the output registers.

Test Plan:
- Reset then idle: rst pulse, in_valid=1, no start -> in_ready=0, wr_en=0 and busy=0 for 20 cycles.
- Full frame, continuous: start, then 16 beats with in_valid=1 and data 0x00..0x0F -> 16 writes on consecutive cycles, each 1 cycle after its accept. (i,j) runs (0,0),(0,1)...(3,3) with wr_data = 4*i+j. done=1 exactly with the (3,3) write. busy drops the cycle after.
- Bubbles: in_valid toggling 1,0,1,0... with data 0xA0+k -> writes only after accepted beats. Addresses stay contiguous 0..15. done after the 16th accept. No write in bubble-following cycles.
- Abort mid-frame: abort after 5 accepts -> exactly 5 writes (addresses 0..4). done never asserts. A new start then begins at (0,0).
- Start ignored while busy, and reset mid-frame:
  - start pulses during RUN -> no counter reset.
  - rst after 7 accepts -> all outputs 0 immediately; next frame starts at (0,0).
- WRITE_ADDR_TRANSPOSE_EN with transpose=1 at start, data 0..15 -> order (0,0),(1,0),(2,0),(3,0),(0,1)... and the word at (i,j) equals 4*j+i.
